// File: rtl/sub_8_bit_serial.sv
// Bit-serial unsigned subtractor: z = x - y, LSB first, one bit per clock.
// A single borrow flip-flop carries between bit slices; z/borrow only change on completion.
module sub_8_bit_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             borrow,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_r;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_z;
  logic             r_borrow;

  logic w_d, w_br_nxt, w_last;

  // Full-subtractor slice on the current LSBs.
  assign w_d      = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_nxt = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_last   = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_z      <= '0;
      r_borrow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a   <= x;
          r_b   <= y;
          r_br  <= 1'b0;
          r_cnt <= '0;
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br_nxt;
          r_r   <= {w_d, r_r[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          // Publish the whole result at once so z is never seen half-built.
          if (w_last) begin
            r_z      <= {w_d, r_r[WIDTH-1:1]};
            r_borrow <= w_br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign z      = r_z;
  assign borrow = r_borrow;
  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE);
endmodule

// File: tb/tb_sub_8_bit_serial.sv
// Directed + randomized bench for sub_8_bit_serial; expected values come from plain x-y arithmetic.
module tb_sub_8_bit_serial;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = '0, y = '0;
  logic [7:0] z;
  logic       borrow, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] held_z = '0;
  logic       held_b = 1'b0;

  sub_8_bit_serial #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .z(z), .borrow(borrow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_z(input int a, input int b);
    return 8'((a - b + 256) % 256);
  endfunction

  task automatic launch(input logic [7:0] ax, input logic [7:0] ay);
    @(negedge clk);
    x = ax; y = ay; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    x = 8'($urandom); y = 8'($urandom);
  endtask

  // Called at the negedge right after the accepting edge; watches busy until done.
  task automatic finish_op(input logic [7:0] ax, input logic [7:0] ay, input bit poke,
                           input bit full, input string tag);
    int nbusy = 0;
    bit seen  = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) nbusy++;
        if (full) check({tag, "_zhold"}, {23'd0, z, borrow}, {23'd0, held_z, held_b});
        if (poke && i == 0) begin x = 8'd1; y = 8'd1; start = 1'b1; end
        if (poke && i == 1) start = 1'b0;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    held_z = ref_z(int'(ax), int'(ay));
    held_b = (ax < ay);
    if (full) begin
      check({tag, "_busy_cnt"}, 32'(nbusy), 32'd8);
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    check({tag, "_z"}, 32'(z), 32'(held_z));
    check({tag, "_borrow"}, 32'(borrow), 32'(held_b));
    @(negedge clk);
    if (full) check({tag, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int gap;
    bit any_done;
    logic [7:0] ra, rb;

    #12;
    check("rst_outs", {22'd0, z, borrow, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("rst_noX", 32'(^{z, borrow, busy, done}), 32'(^{8'd0, 4'd0}));

    launch(8'd10, 8'd2);    finish_op(8'd10, 8'd2, 0, 1, "t10_2");
    launch(8'd2, 8'd10);    finish_op(8'd2, 8'd10, 0, 1, "t2_10");
    launch(8'd0, 8'd1);     finish_op(8'd0, 8'd1, 0, 1, "t0_1");
    launch(8'd35, 8'd35);   finish_op(8'd35, 8'd35, 0, 1, "t35_35");
    launch(8'd255, 8'd0);   finish_op(8'd255, 8'd0, 0, 1, "t255_0");
    launch(8'd0, 8'd255);   finish_op(8'd0, 8'd255, 0, 1, "t0_255");
    launch(8'd35, 8'd2);    finish_op(8'd35, 8'd2, 1, 1, "ignore");
    check("ignore_idle", 32'(busy), 32'd0);

    // Held start: back-to-back operations, one done every 10 cycles.
    @(negedge clk);
    x = 8'd200; y = 8'd100; start = 1'b1;
    gap = 0;
    while (!done && gap < 30) begin @(negedge clk); gap++; end
    check("held_first", 32'(done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      @(negedge clk); gap++;
      while (!done && gap < 30) begin @(negedge clk); gap++; end
      check("held_period", 32'(gap), 32'd10);
      check("held_z", 32'(z), 32'd100);
      check("held_borrow", 32'(borrow), 32'd0);
      check("held_excl", 32'(busy & done), 32'd0);
    end
    start = 1'b0;
    held_z = 8'd100; held_b = 1'b0;
    @(negedge clk); @(negedge clk);

    // Reset during the 4th SHIFT cycle abandons the operation.
    launch(8'd100, 8'd50);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_outs", {22'd0, z, borrow, busy, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    held_z = '0; held_b = 1'b0;
    any_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) any_done = 1;
      @(negedge clk);
    end
    check("midrst_nodone", 32'(any_done), 32'd0);
    check("midrst_z", {23'd0, z, borrow}, 32'd0);
    launch(8'd100, 8'd50);  finish_op(8'd100, 8'd50, 0, 1, "after_rst");

    // Random sweep against plain subtraction.
    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      launch(ra, rb);
      finish_op(ra, rb, 0, (n < 20), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
